// File: rtl/alu16_nibble_seq.sv
// Nibble-serial ALU: captures operands on accept, then works through one
// 4-bit slice per cycle (LSB first) with a registered ripple carry, and
// publishes f/cout/equal/zero together on a final commit cycle.
//
// Handshakes: a request transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where res_valid & res_ready. in_ready is
// high only in IDLE, and res_valid is held high (with stable outputs) until
// the result transfers.
module alu16_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 cn,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] f,
  output logic                 cout,
  output logic                 equal,
  output logic                 zero,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    s_q, s_d;
  logic          m_q, m_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  f_q, f_d;
  logic          cout_q, cout_d, equal_q, equal_d, zero_q, zero_d;

  logic [3:0]    an, bn, xn, yn, ln, nib_res;
  logic [4:0]    sum_n;
  logic          nib_carry;

  // One nibble of datapath: operand selection, logic function and 4-bit add.
  always_comb begin
    an = a_q[4*cnt_q +: 4];
    bn = b_q[4*cnt_q +: 4];
    ln = 4'h0;
    xn = an;
    yn = 4'h0;
    case (s_q)
      4'h0: ln = ~an;
      4'h1: ln = ~(an | bn);
      4'h2: ln = ~an & bn;
      4'h3: ln = 4'h0;
      4'h4: ln = ~(an & bn);
      4'h5: ln = ~bn;
      4'h6: ln = an ^ bn;
      4'h7: ln = an & ~bn;
      4'h8: ln = ~an | bn;
      4'h9: ln = ~(an ^ bn);
      4'hA: ln = bn;
      4'hB: ln = an & bn;
      4'hC: ln = 4'hF;
      4'hD: ln = an | ~bn;
      4'hE: ln = an | bn;
      default: ln = an;
    endcase
    case (s_q)
      4'h0: begin xn = an;        yn = 4'h0;      end
      4'h1: begin xn = an | bn;   yn = 4'h0;      end
      4'h2: begin xn = an | ~bn;  yn = 4'h0;      end
      4'h3: begin xn = 4'h0;      yn = 4'hF;      end
      4'h4: begin xn = an;        yn = an & ~bn;  end
      4'h5: begin xn = an | bn;   yn = an & ~bn;  end
      4'h6: begin xn = an;        yn = ~bn;       end
      4'h7: begin xn = an & ~bn;  yn = 4'hF;      end
      4'h8: begin xn = an;        yn = an & bn;   end
      4'h9: begin xn = an;        yn = bn;        end
      4'hA: begin xn = an | ~bn;  yn = an & bn;   end
      4'hB: begin xn = an & bn;   yn = 4'hF;      end
      4'hC: begin xn = an;        yn = an;        end
      4'hD: begin xn = an | bn;   yn = an;        end
      4'hE: begin xn = an | ~bn;  yn = an;        end
      default: begin xn = an;     yn = 4'hF;      end
    endcase
    sum_n     = {1'b0, xn} + {1'b0, yn} + {4'b0000, carry_q};
    nib_res   = m_q ? ln : sum_n[3:0];
    nib_carry = m_q ? 1'b0 : sum_n[4];
  end

  // Next-state and register updates for IDLE -> CALC -> DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    acc_d   = acc_q;
    f_d     = f_q;
    cout_d  = cout_q;
    equal_d = equal_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = cn;
          cnt_d   = '0;
          last_d  = 1'b0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!last_q) begin
          acc_d[4*cnt_q +: 4] = nib_res;
          carry_d = nib_carry;
          if (cnt_q == CW'(NIBBLES - 1)) last_d = 1'b1;
          else                           cnt_d  = cnt_q + CW'(1);
        end else begin
          // Commit: the partial accumulator only becomes visible here.
          f_d     = acc_q;
          cout_d  = m_q ? 1'b0 : carry_q;
          equal_d = (a_q == b_q);
          zero_d  = (acc_q == '0);
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      equal_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      equal_q <= equal_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign f         = f_q;
  assign cout      = cout_q;
  assign equal     = equal_q;
  assign zero      = zero_q;
endmodule

// File: doc/alu16_nibble_seq.md
ALU16_NIBBLE_SEQ -- requirements
Module: alu16_nibble_seq

Interface
REQ-001 The module SHALL have one parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES (W = 16 at default).
REQ-002 The module SHALL have these ports, clock and reset first (one clock; reset is synchronous and active-low):
- clk  input  1  sole clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request (IDLE only)
- a  input  W  operand A
- b  input  W  operand B
- s  input  4  function select
- m  input  1  1 = logic mode, 0 = arithmetic mode
- cn  input  1  carry-in, active-high (1 = add one)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- f  output  W  result
- cout  output  1  carry out of bit W-1 (arithmetic mode; 0 in logic mode)
- equal  output  1  A == B over full W bits
- zero  output  1  f == 0
- busy  output  1  state is CALC or DONE

Function
REQ-003 The module SHALL implement a state machine with states IDLE, CALC, DONE; in_ready = (state == IDLE).
REQ-004 IDLE -> CALC on in_valid & in_ready; a, b, s, m, cn SHALL be registered at that edge, and input changes after acceptance SHALL have no effect.
REQ-005 CALC SHALL process exactly one nibble per cycle, LSB nibble first, using a nibble counter 0..NIBBLES-1; the carry out of nibble k SHALL be registered and used as carry-in of nibble k+1; nibble 0 uses cn.
REQ-006 CALC -> DONE after nibble NIBBLES-1; res_valid SHALL rise at the (NIBBLES+1)th rising edge after the accept edge (5 at default) and stay high in DONE.
REQ-007 DONE -> IDLE on res_ready & res_valid; f, cout, equal, zero SHALL hold stable throughout DONE and retain their values in IDLE until the next result is written.
REQ-008 in_valid SHALL be ignored while busy; no request queuing.
REQ-009 Logic mode (m=1), bitwise, no carry: s=0 ~A; 1 ~(A|B); 2 ~A&B; 3 all-zeros; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B; 8 ~A|B; 9 ~(A^B); A B; B A&B; C all-ones; D A|~B; E A|B; F A.
REQ-010 Arithmetic mode (m=0) SHALL compute f = X + Y + cn modulo 2^W with cout = carry out of bit W-1, where (X, Y) per s: 0 (A,0); 1 (A|B,0); 2 (A|~B,0); 3 (0,all-ones); 4 (A,A&~B); 5 (A|B,A&~B); 6 (A,~B); 7 (A&~B,all-ones); 8 (A,A&B); 9 (A,B); A (A|~B,A&B); B (A&B,all-ones); C (A,A); D (A|B,A); E (A|~B,A); F (A,all-ones).
REQ-011 X and Y SHALL be formed bitwise per nibble so the nibble-serial result equals the full-width result of REQ-010 for all operands.
REQ-012 equal SHALL be computed from the registered operands and updated together with f; zero SHALL equal (f == 0) in both modes.

Reset
REQ-013 On a rising edge with rst_n = 0, state SHALL become IDLE, nibble counter 0, f = 0, cout = 0, equal = 0, zero = 0, res_valid = 0, busy = 0, in_ready = 1 from the next cycle.
REQ-014 Reset asserted in CALC or DONE SHALL abort the operation with no partial result visible and no res_valid pulse.
REQ-015 After reset deassertion, a request SHALL be acceptable on the first edge with rst_n = 1.

Verification
REQ-016 m=0, s=9, cn=0, a=0x1234, b=0x0FFF -> f=0x2233, cout=0, equal=0, res_valid exactly 5 edges after accept.
REQ-017 m=0, s=6, cn=1, a=0x0005, b=0x0007 -> f=0xFFFE, cout=0; repeat with a=0x0007, b=0x0005 -> f=0x0002, cout=1.
REQ-018 m=0, s=9, cn=1, a=0xFFFF, b=0x0000 -> f=0x0000, cout=1, zero=1 (carry ripples through all nibbles).
REQ-019 m=1, s=6, a=0xAAAA, b=0xAAAA -> f=0x0000, zero=1, equal=1, cout=0; m=1, s=C -> f=0xFFFF.
REQ-020 res_ready held low 3 cycles in DONE with in_valid=1 -> f and res_valid stable, in_ready=0, no new accept; res_ready=1 -> IDLE next cycle, then request accepted.
REQ-021 rst_n=0 during CALC at nibble 2 -> next cycle state IDLE, res_valid=0, f=0, in_ready=1; no res_valid pulse afterwards.
